// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the shared-memory round-robin arbiter.
// Imported by mem_arbiter and rr_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } arb_state_e;

    localparam logic [1:0] MemctlIdle  = 2'b00;
    localparam logic [1:0] MemctlRead  = 2'b01;
    localparam logic [1:0] MemctlWrite = 2'b10;
    localparam logic [1:0] MemctlRsvd  = 2'b11;

    // Index width for n items; never below 1 so single-entry vectors stay legal.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 0;
        while ((32'd1 << w) < n) begin
            w++;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first eligible requester after last_i, wrapping.
// Produces a one-hot grant, its index and a valid flag.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [N-1:0]    mask_i,
    input  logic [IdxW-1:0] last_i,
    output logic [N-1:0]    gnt_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    logic [N-1:0] elig;
    int unsigned  cand;

    assign elig = req_i & ~mask_i;

    // Offsets 1..N visit every core once, ending on last_i itself.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(last_i) + k) % N;
            if (!valid_o && elig[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising per-core read/write requests onto one synchronous
// memory port; returns per-core read data, a done pulse and a stall flag.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NumCores = 4,
    parameter int unsigned AddrW    = 16,
    parameter int unsigned DataW    = 16,
    parameter int unsigned MemLat   = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [2*NumCores-1:0]     core_memctl_i,
    input  logic [AddrW*NumCores-1:0] core_addr_i,
    input  logic [DataW*NumCores-1:0] core_wdata_i,
    output logic [DataW*NumCores-1:0] core_rdata_o,
    output logic [NumCores-1:0]       core_done_o,
    output logic [NumCores-1:0]       core_stall_o,
    output logic [NumCores-1:0]       core_grant_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [AddrW-1:0]          mem_addr_o,
    output logic [DataW-1:0]          mem_wdata_o,
    input  logic [DataW-1:0]          mem_rdata_i
);

    localparam int unsigned IdxW = clog2(NumCores);
    localparam int unsigned CntW = clog2(MemLat);

    arb_state_e                           state_q;
    logic       [IdxW-1:0]                idx_q;
    logic       [IdxW-1:0]                last_q;
    logic       [NumCores-1:0]            mask_q;
    logic                                 write_q;
    logic       [CntW-1:0]                cnt_q;
    logic       [NumCores-1:0]            grant_q;
    logic       [NumCores-1:0]            done_q;
    logic                                 mem_en_q;
    logic                                 mem_we_q;
    logic       [AddrW-1:0]               mem_addr_q;
    logic       [DataW-1:0]               mem_wdata_q;
    logic       [NumCores-1:0][DataW-1:0] rdata_q;

    logic [NumCores-1:0] req;
    logic [NumCores-1:0] pick_gnt;
    logic [IdxW-1:0]     pick_idx;
    logic                pick_valid;
    logic [1:0]          sel_op_d;
    logic [AddrW-1:0]    sel_addr_d;
    logic [DataW-1:0]    sel_wdata_d;

    always_comb begin
        req = '0;
        for (int i = 0; i < int'(NumCores); i++) begin
            unique case (core_memctl_i[2*i +: 2])
                MemctlRead, MemctlWrite: req[i] = 1'b1;
                MemctlIdle, MemctlRsvd:  req[i] = 1'b0;
                default:                 req[i] = 1'b0;
            endcase
        end
    end

    rr_arbiter #(
        .N    (NumCores),
        .IdxW (IdxW)
    ) u_rr_arbiter (
        .req_i   (req),
        .mask_i  (mask_q),
        .last_i  (last_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        sel_op_d    = core_memctl_i[2*pick_idx +: 2];
        sel_addr_d  = core_addr_i[AddrW*pick_idx +: AddrW];
        sel_wdata_d = core_wdata_i[DataW*pick_idx +: DataW];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            last_q      <= IdxW'(NumCores - 1);
            mask_q      <= '0;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            done_q   <= '0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The just-served core is hidden for this one cycle only.
                    mask_q <= '0;
                    if (pick_valid) begin
                        idx_q       <= pick_idx;
                        write_q     <= (sel_op_d == MemctlWrite);
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= (sel_op_d == MemctlWrite);
                        grant_q     <= pick_gnt;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= CntW'(MemLat - 1);
                    state_q <= StWait;
                end
                StWait: begin
                    if (cnt_q == '0) begin
                        if (!write_q) begin
                            rdata_q[idx_q] <= mem_rdata_i;
                        end
                        done_q  <= grant_q;
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    last_q  <= idx_q;
                    mask_q  <= grant_q;
                    grant_q <= '0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core_rdata_o = rdata_q;
    assign core_done_o  = done_q;
    assign core_grant_o = grant_q;
    assign core_stall_o = req & ~done_q & {NumCores{~rst_i}};
    assign mem_en_o     = mem_en_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-timeline model checks the MEM_LAT=1
// instance every cycle; directed literal checks pin both instances (MEM_LAT=1 and 3).
module tb_mem_arbiter;

    localparam int Lat = 1;

    logic        clk = 1'b0;
    logic        rst, rst3;
    logic [7:0]  memctl, memctl3;
    logic [63:0] addr, wdata, addr3, wdata3, rdata, rdata3;
    logic [3:0]  done, stall, grant, done3, stall3, grant3;
    logic        mem_en, mem_we, mem_en3, mem_we3;
    logic [15:0] mem_addr, mem_wdata, mem_addr3, mem_wdata3;
    logic [15:0] mem_rdata = '0, mem_rdata3 = '0, p1 = '0, p2 = '0;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NumCores(4), .AddrW(16), .DataW(16), .MemLat(1)) dut (
        .clk_i(clk), .rst_i(rst), .core_memctl_i(memctl), .core_addr_i(addr),
        .core_wdata_i(wdata), .core_rdata_o(rdata), .core_done_o(done), .core_stall_o(stall),
        .core_grant_o(grant), .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    mem_arbiter #(.NumCores(4), .AddrW(16), .DataW(16), .MemLat(3)) dut3 (
        .clk_i(clk), .rst_i(rst3), .core_memctl_i(memctl3), .core_addr_i(addr3),
        .core_wdata_i(wdata3), .core_rdata_o(rdata3), .core_done_o(done3),
        .core_stall_o(stall3), .core_grant_o(grant3), .mem_en_o(mem_en3), .mem_we_o(mem_we3),
        .mem_addr_o(mem_addr3), .mem_wdata_o(mem_wdata3), .mem_rdata_i(mem_rdata3)
    );

    // Memories: one-cycle sync RAM for dut, three-stage read pipe for dut3.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
        if (mem_en3 && !mem_we3) p1 <= mem[mem_addr3];
        p2         <= p1;
        mem_rdata3 <= p2;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit req_of(input logic [7:0] mc, input int i);
        return (mc[2*i +: 2] == 2'b01) || (mc[2*i +: 2] == 2'b10);
    endfunction

    // Model: a transaction is a timeline. Age 1 = issue, 2..1+Lat = wait, 2+Lat = done.
    int          m_age = 0, m_owner = 0, m_last = 3, m_blocked = -1, m_c;
    bit          m_write, m_found, chk_en = 0;
    logic [15:0] m_addr, m_wdata;
    logic [15:0] m_rdata [4];

    always @(posedge clk) begin
        chk_en = 1'b1;
        if (rst) begin
            m_age = 0; m_last = 3; m_blocked = -1;
            for (int i = 0; i < 4; i++) m_rdata[i] = '0;
        end else if (m_age == 0) begin
            m_found = 0;
            for (int k = 1; k <= 4; k++) begin
                m_c = (m_last + k) % 4;
                if (!m_found && req_of(memctl, m_c) && m_c != m_blocked) begin
                    m_found = 1; m_owner = m_c; m_age = 1;
                    m_write = (memctl[2*m_c +: 2] == 2'b10);
                    m_addr  = addr[16*m_c +: 16];
                    m_wdata = wdata[16*m_c +: 16];
                end
            end
            m_blocked = -1;
        end else if (m_age == 2 + Lat) begin
            m_age = 0; m_last = m_owner; m_blocked = m_owner;
        end else begin
            if (m_age == 1 && m_write) ref_mem[m_addr] = m_wdata;
            if (m_age == 1 + Lat && !m_write) m_rdata[m_owner] = ref_mem[m_addr];
            m_age++;
        end
    end

    always @(negedge clk) begin
        logic [3:0]  eg, ed, es;
        logic [63:0] er;
        if (chk_en) begin
            eg = (m_age > 0) ? 4'(1 << m_owner) : 4'b0;
            ed = (m_age == 2 + Lat) ? 4'(1 << m_owner) : 4'b0;
            for (int i = 0; i < 4; i++) begin
                es[i] = req_of(memctl, i) && !ed[i] && !rst;
                er[16*i +: 16] = m_rdata[i];
            end
            check("m_grant", grant, eg);
            check("m_done", done, ed);
            check("m_stall", stall, es);
            check("m_rdata", rdata, er);
            check("m_mem_en", mem_en, (m_age == 1));
            check("m_mem_we", mem_we, (m_age == 1) && m_write);
            if (m_age == 1) check("m_mem_addr", mem_addr, m_addr);
            if (m_age == 1 && m_write) check("m_mem_wdata", mem_wdata, m_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic [1:0] op, input logic [15:0] a,
                            input logic [15:0] d);
        memctl[2*i +: 2] = op;
        addr[16*i +: 16] = a;
        wdata[16*i +: 16] = d;
    endtask

    task automatic set3(input int i, input logic [1:0] op, input logic [15:0] a);
        memctl3[2*i +: 2] = op;
        addr3[16*i +: 16] = a;
    endtask

    function automatic int onehot_idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int order [5];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int n_seen, n_we;

        for (int a = 0; a < 65536; a++) begin
            mem[a]     = 16'(a) ^ 16'h5A5A;
            ref_mem[a] = 16'(a) ^ 16'h5A5A;
        end
        mem[16'h0040] = 16'hBEEF; ref_mem[16'h0040] = 16'hBEEF;
        mem[16'h0020] = 16'h5A5A; ref_mem[16'h0020] = 16'h5A5A;
        mem[16'h0050] = 16'hC0DE; ref_mem[16'h0050] = 16'hC0DE;
        mem[16'h0060] = 16'h1111; ref_mem[16'h0060] = 16'h1111;
        mem[16'h0070] = 16'h7777; ref_mem[16'h0070] = 16'h7777;
        for (int i = 0; i < 4; i++) begin
            mem[16'h0100 + i]     = 16'hA000 + 16'(i);
            ref_mem[16'h0100 + i] = 16'hA000 + 16'(i);
        end

        // 1: reset with all cores reading, then round-robin order.
        rst = 1; rst3 = 1;
        memctl = 8'h55; memctl3 = '0; wdata = '0; addr3 = '0; wdata3 = '0;
        for (int i = 0; i < 4; i++) addr[16*i +: 16] = 16'h0100 + 16'(i);
        repeat (3) begin
            @(negedge clk);
            check("t1_rst_grant", grant, 0);
            check("t1_rst_mem_en", mem_en, 0);
            check("t1_rst_done", done, 0);
            check("t1_rst_stall", stall, 0);
            check("t1_rst_rdata", rdata, 0);
            check("t1_rst_mem_addr", mem_addr, 0);
            check("t1_rst3_grant", grant3, 0);
        end
        tick();
        rst = 0; rst3 = 0;
        n_seen = 0;
        for (int c = 0; c < 60 && n_seen < 5; c++) begin
            @(negedge clk);
            if (done != 0) begin
                order[n_seen] = onehot_idx(done);
                n_seen++;
            end
        end
        tick();
        memctl = '0;
        check("t1_done_count", n_seen, 5);
        for (int k = 0; k < 5; k++) check("t1_order", order[k], exp_order[k]);
        check("t1_rdata0", rdata[15:0], 16'hA000);
        tick(); tick();

        // 2: core1 reads 0x0040.
        set_core(1, 2'b01, 16'h0040, 16'h0);
        @(negedge clk); check("t2_c0_grant", grant, 0);
        tick();
        @(negedge clk);
        check("t2_c1_mem_en", mem_en, 1);
        check("t2_c1_mem_addr", mem_addr, 16'h0040);
        check("t2_c1_grant", grant, 4'b0010);
        check("t2_c1_stall", stall, 4'b0010);
        tick(); tick();
        @(negedge clk);
        check("t2_c3_done", done, 4'b0010);
        check("t2_c3_rdata1", rdata[31:16], 16'hBEEF);
        check("t2_c3_stall", stall, 0);
        tick();
        set_core(1, 2'b00, 16'h0, 16'h0);
        tick(); tick();

        // 3: core2 writes 0x1234 to 0x0010.
        set_core(2, 2'b10, 16'h0010, 16'h1234);
        n_we = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_en && mem_we) n_we++;
            if (c == 1) begin
                check("t3_mem_addr", mem_addr, 16'h0010);
                check("t3_mem_wdata", mem_wdata, 16'h1234);
            end
            if (c == 3) check("t3_done", done, 4'b0100);
            tick();
            if (c == 3) set_core(2, 2'b00, 16'h0, 16'h0);
        end
        check("t3_we_cycles", n_we, 1);
        check("t3_rdata2_kept", rdata[47:32], 16'hA002);
        check("t3_mem_written", mem[16'h0010], 16'h1234);

        // 4: core3 drops its request in WAIT; then reserved code everywhere.
        set_core(3, 2'b01, 16'h0020, 16'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 3) begin
                check("t4_done", done, 4'b1000);
                check("t4_rdata3", rdata[63:48], 16'h5A5A);
            end
            tick();
            if (c == 1) set_core(3, 2'b00, 16'h0, 16'h0);
        end
        memctl = 8'hFF;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t4_rsvd_grant", grant, 0);
            check("t4_rsvd_mem_en", mem_en, 0);
            tick();
        end
        memctl = '0;
        tick();

        // 5: masking of the just-served core.
        set_core(0, 2'b01, 16'h0030, 16'h0);
        set_core(1, 2'b01, 16'h0040, 16'h0);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            if (c == 3)  check("t5_done0_a", done, 4'b0001);
            if (c == 5)  check("t5_grant1", grant, 4'b0010);
            if (c == 7)  check("t5_done1", done, 4'b0010);
            if (c == 9)  check("t5_grant0_b", grant, 4'b0001);
            if (c == 11) check("t5_done0_b", done, 4'b0001);
            if (c == 12) check("t5_gap_c12", grant, 0);
            if (c == 13) check("t5_gap_c13", grant, 0);
            if (c == 14) begin
                check("t5_regrant0", grant, 4'b0001);
                check("t5_regrant_en", mem_en, 1);
            end
            if (c == 16) check("t5_done0_c", done, 4'b0001);
            tick();
            if (c == 7)  set_core(1, 2'b00, 16'h0, 16'h0);
            if (c == 14) set_core(0, 2'b00, 16'h0, 16'h0);
        end

        // 6: MEM_LAT=3 instance: full read, reset in 2nd WAIT, then a clean read.
        set3(0, 2'b01, 16'h0050);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 4) check("t6a_no_early_done", done3, 0);
            if (c == 5) begin
                check("t6a_done", done3, 4'b0001);
                check("t6a_rdata0", rdata3[15:0], 16'hC0DE);
            end
            tick();
            if (c == 5) set3(0, 2'b00, 16'h0);
        end
        set3(1, 2'b01, 16'h0060);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (c == 3) check("t6b_rst_stall", stall3, 0);
            if (c >= 4) check("t6b_no_done", done3, 0);
            if (c == 4) begin
                check("t6b_grant", grant3, 0);
                check("t6b_mem_en", mem_en3, 0);
                check("t6b_rdata", rdata3, 0);
            end
            tick();
            if (c == 2) rst3 = 1;
            if (c == 3) begin
                rst3 = 0;
                set3(1, 2'b00, 16'h0);
            end
        end
        set3(2, 2'b01, 16'h0070);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c == 1) check("t6c_mem_en", mem_en3, 1);
            if (c == 4) check("t6c_no_early_done", done3, 0);
            if (c == 5) begin
                check("t6c_done", done3, 4'b0100);
                check("t6c_rdata2", rdata3[47:32], 16'h7777);
            end
            tick();
            if (c == 5) set3(2, 2'b00, 16'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
